qch_sync_bank: RTL and testbench

QCH_SYNC_BANK -- requirements
Module: qch_sync_bank

---
 rtl/qch_pkg.sv | 32 +++
 rtl/qch_sync_cell.sv | 126 ++++++++++++
 rtl/qch_sync_bank.sv | 77 +++++++
 tb/tb_qch_sync_bank.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qch_pkg.sv
// -----------------------------------------------------------------------------
// qch_pkg
//   Shared constants and helpers for the Q-channel synchronizer bank.
//   Legal ranges for the bank parameters live here so that the top-level
//   elaboration checks and any integrating block agree on the same limits.
// -----------------------------------------------------------------------------
package qch_pkg;

    // Synchronizer depth limits: two flops is the minimum for metastability
    // settling, four is the deepest chain the bank supports.
    localparam int QCH_MIN_STAGES = 2;
    localparam int QCH_MAX_STAGES = 4;

    // Stability filter limit; 0 means the filter is bypassed.
    localparam int QCH_MAX_FILTER = 255;

    // Channel count limits.
    localparam int QCH_MIN_WIDTH  = 1;
    localparam int QCH_MAX_WIDTH  = 32;

    // Width of the per-channel stability counter. The counter only has to
    // reach FILTER_CYCLES-1, but clog2(F+1) is kept so the count range
    // always covers F. A disabled filter still gets a 1-bit width so that
    // no zero-width vector is ever declared.
    function automatic int qch_cnt_width(input int filter_cycles);
        if (filter_cycles < 1) begin
            return 1;
        end
        return $clog2(filter_cycles + 1);
    endfunction

endpackage : qch_pkg

// File: rtl/qch_sync_cell.sv
// -----------------------------------------------------------------------------
// qch_sync_cell
//   One Q-channel synchronizer lane: a STAGES-deep flop chain, an optional
//   stability filter, and a registered edge detector.
//
//   Parameters
//     STAGES        synchronizer depth (2..4)
//     FILTER_CYCLES stability filter length, 0 bypasses the filter
//     RESET_BIT     reset level of every flop in the lane
//
//   Ports
//     clk       sampling clock
//     reset     asynchronous, active-high reset
//     async_in  unsynchronized input level
//     sync_out  synchronized (and filtered) level
//     rise      one-cycle pulse on a 0->1 change of sync_out
//     fall      one-cycle pulse on a 1->0 change of sync_out
// -----------------------------------------------------------------------------
module qch_sync_cell
    import qch_pkg::*;
#(
    parameter int   STAGES        = 2,
    parameter int   FILTER_CYCLES = 0,
    parameter logic RESET_BIT     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    // -------------------------------------------------------------------------
    // Synchronizer chain. Bit 0 samples the asynchronous input; the last bit
    // is the first value considered safe to use in the clk domain.
    // -------------------------------------------------------------------------
    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
    logic                                        stage_s;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the
    // chain into a single flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_BIT}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
        end
    end

    assign stage_s = sync_q[STAGES-1];

    // -------------------------------------------------------------------------
    // Stability filter. The output only adopts a new synchronized level once
    // that level has disagreed with the output for FILTER_CYCLES consecutive
    // edges; any shorter excursion resets the count and is forgotten.
    // -------------------------------------------------------------------------
    logic level;

    if (FILTER_CYCLES == 0) begin : g_no_filter

        assign level = stage_s;

    end else begin : g_filter

        localparam int              CNT_W    = qch_cnt_width(FILTER_CYCLES);
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

        logic             out_q;
        logic             out_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        // NOTE: every signal driven here gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        always_comb begin
            out_d = out_q;
            cnt_d = '0;
            if (stage_s != out_q) begin
                if (cnt_q == CNT_LAST) begin
                    // Disagreement has lasted long enough: accept it.
                    out_d = stage_s;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        // Reset clears the count too, so a filter window that straddles a
        // reset always restarts from zero after release.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                out_q <= RESET_BIT;
                cnt_q <= '0;
            end else begin
                out_q <= out_d;
                cnt_q <= cnt_d;
            end
        end

        assign level = out_q;

    end

    // -------------------------------------------------------------------------
    // Edge detect. The delayed copy resets to the same level as the output,
    // so no pulse can appear during reset or in the first cycle after it.
    // Both inputs of the decode are flops, so there is no combinational path
    // from async_in to rise/fall.
    // -------------------------------------------------------------------------
    logic dly_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dly_q <= RESET_BIT;
        end else begin
            dly_q <= level;
        end
    end

    assign sync_out = level;
    assign rise     =  level & ~dly_q;
    assign fall     = ~level &  dly_q;

endmodule : qch_sync_cell

// File: rtl/qch_sync_bank.sv
// -----------------------------------------------------------------------------
// qch_sync_bank
//   Bank of WIDTH independent Q-channel level synchronizers with optional
//   stability filtering and per-channel edge pulses.
//
//   Parameters
//     WIDTH         number of channels (1..32)
//     STAGES        synchronizer depth per channel (2..4)
//     RESET_VAL     per-channel reset level; the Q-channel idle level is high
//     FILTER_CYCLES stability filter length (0..255), 0 bypasses the filter
//
//   Ports
//     clk       sampling clock
//     reset     asynchronous, active-high reset; release must already be
//               synchronous to clk, this block does not synchronize it
//     async_in  unsynchronized inputs, one per channel
//     sync_out  synchronized and filtered levels
//     rise      one-cycle pulse per channel on a 0->1 change of sync_out
//     fall      one-cycle pulse per channel on a 1->0 change of sync_out
//     changed   high whenever any rise or fall bit is high
// -----------------------------------------------------------------------------
module qch_sync_bank
    import qch_pkg::*;
#(
    parameter int               WIDTH         = 4,
    parameter int               STAGES        = 2,
    parameter logic [WIDTH-1:0] RESET_VAL     = '1,
    parameter int               FILTER_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks.
    // -------------------------------------------------------------------------
    if (WIDTH < QCH_MIN_WIDTH || WIDTH > QCH_MAX_WIDTH) begin : g_bad_width
        $error("qch_sync_bank: WIDTH=%0d outside %0d..%0d",
               WIDTH, QCH_MIN_WIDTH, QCH_MAX_WIDTH);
    end

    if (STAGES < QCH_MIN_STAGES || STAGES > QCH_MAX_STAGES) begin : g_bad_stages
        $error("qch_sync_bank: STAGES=%0d outside %0d..%0d",
               STAGES, QCH_MIN_STAGES, QCH_MAX_STAGES);
    end

    if (FILTER_CYCLES < 0 || FILTER_CYCLES > QCH_MAX_FILTER) begin : g_bad_filter
        $error("qch_sync_bank: FILTER_CYCLES=%0d outside 0..%0d",
               FILTER_CYCLES, QCH_MAX_FILTER);
    end

    // -------------------------------------------------------------------------
    // One fully independent cell per channel.
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        qch_sync_cell #(
            .STAGES        (STAGES),
            .FILTER_CYCLES (FILTER_CYCLES),
            .RESET_BIT     (RESET_VAL[i])
        ) u_cell (
            .clk      (clk),
            .reset    (reset),
            .async_in (async_in[i]),
            .sync_out (sync_out[i]),
            .rise     (rise[i]),
            .fall     (fall[i])
        );
    end

    assign changed = |(rise | fall);

endmodule : qch_sync_bank

// File: tb/tb_qch_sync_bank.sv
// -----------------------------------------------------------------------------
// tb_qch_sync_bank
//   Four bank instances with different STAGES/FILTER_CYCLES settings share a
//   clock and reset. A behavioural model tracks every channel of every
//   instance: a sample-history pipe for the synchronizer, an "adopt after F
//   consecutive disagreeing edges" rule for the filter, and the previous
//   output for edge pulses.
// -----------------------------------------------------------------------------
module tb_qch_sync_bank;

    localparam int NDUT = 4;
    localparam int W    = 4;
    localparam int S_OF [NDUT] = '{2, 3, 2, 2};
    localparam int F_OF [NDUT] = '{0, 4, 8, 2};

    logic           clk;
    logic           reset;
    logic [W-1:0]   in_v  [NDUT];
    logic [W-1:0]   so    [NDUT];
    logic [W-1:0]   ri    [NDUT];
    logic [W-1:0]   fa    [NDUT];
    logic           ch    [NDUT];

    int tests_run;
    int fails;

    // ---------------------------------------------------------------- DUTs
    qch_sync_bank #(.WIDTH(4), .STAGES(2), .RESET_VAL(4'hF), .FILTER_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .async_in(in_v[0]), .sync_out(so[0]),
        .rise(ri[0]), .fall(fa[0]), .changed(ch[0]));
    qch_sync_bank #(.WIDTH(4), .STAGES(3), .RESET_VAL(4'hF), .FILTER_CYCLES(4)) dut1 (
        .clk(clk), .reset(reset), .async_in(in_v[1]), .sync_out(so[1]),
        .rise(ri[1]), .fall(fa[1]), .changed(ch[1]));
    qch_sync_bank #(.WIDTH(4), .STAGES(2), .RESET_VAL(4'hF), .FILTER_CYCLES(8)) dut2 (
        .clk(clk), .reset(reset), .async_in(in_v[2]), .sync_out(so[2]),
        .rise(ri[2]), .fall(fa[2]), .changed(ch[2]));
    qch_sync_bank #(.WIDTH(4), .STAGES(2), .RESET_VAL(4'hF), .FILTER_CYCLES(2)) dut3 (
        .clk(clk), .reset(reset), .async_in(in_v[3]), .sync_out(so[3]),
        .rise(ri[3]), .fall(fa[3]), .changed(ch[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // --------------------------------------------------------------- model
    bit pipe  [NDUT][W][4];   // sampled input history, index 0 = newest
    bit m_o   [NDUT][W];      // filtered level
    int m_run [NDUT][W];      // consecutive edges the sampled level disagreed
    bit m_d   [NDUT][W];      // output level one cycle earlier

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++)
            for (int i = 0; i < W; i++) begin
                for (int j = 0; j < 4; j++) pipe[k][i][j] = 1'b1;
                m_o[k][i]   = 1'b1;
                m_d[k][i]   = 1'b1;
                m_run[k][i] = 0;
            end
    endtask

    function automatic bit m_sync(int k, int i);
        if (F_OF[k] == 0) return pipe[k][i][S_OF[k]-1];
        return m_o[k][i];
    endfunction

    function automatic logic [W-1:0] exp_sync(int k);
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = m_sync(k, i);
        return v;
    endfunction

    function automatic logic [W-1:0] exp_rise(int k);
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = m_sync(k, i) & ~m_d[k][i];
        return v;
    endfunction

    function automatic logic [W-1:0] exp_fall(int k);
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = ~m_sync(k, i) & m_d[k][i];
        return v;
    endfunction

    task automatic model_edge();
        bit old_sync;
        bit old_s;
        if (reset) begin
            model_reset();
            return;
        end
        for (int k = 0; k < NDUT; k++)
            for (int i = 0; i < W; i++) begin
                old_sync = m_sync(k, i);
                old_s    = pipe[k][i][S_OF[k]-1];
                for (int j = S_OF[k]-1; j > 0; j--) pipe[k][i][j] = pipe[k][i][j-1];
                pipe[k][i][0] = in_v[k][i];
                if (F_OF[k] > 0) begin
                    if (old_s == m_o[k][i]) m_run[k][i] = 0;
                    else if (m_run[k][i] + 1 >= F_OF[k]) begin
                        m_o[k][i]   = old_s;
                        m_run[k][i] = 0;
                    end else m_run[k][i] = m_run[k][i] + 1;
                end
                m_d[k][i] = old_sync;
            end
    endtask

    // One clock edge: model advances with the DUT, outputs settle 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic ticks(int n);
        for (int t = 0; t < n; t++) tick();
    endtask

    task automatic assert_reset();
        reset = 1'b1;
        model_reset();
    endtask

    // --------------------------------------------------------------- tests
    task automatic test_reset();
        tick();
        in_v[0] = 4'h0;
        assert_reset();
        ticks(3);
        tests_run++;
        if (so[0] !== 4'hF) begin
            fails++; $display("FAIL reset_hold_sync sync_out=%h expected=%h", so[0], 4'hF);
        end
        tests_run++;
        if (ri[0] !== 4'h0 || fa[0] !== 4'h0 || ch[0] !== 1'b0) begin
            fails++; $display("FAIL reset_hold_pulses rise=%h fall=%h changed=%b expected 0", ri[0], fa[0], ch[0]);
        end
        reset = 1'b0;
        tick();
        tests_run++;
        if (so[0] !== 4'hF || fa[0] !== 4'h0 || ch[0] !== 1'b0) begin
            fails++; $display("FAIL reset_edge1 sync_out=%h fall=%h changed=%b expected F/0/0", so[0], fa[0], ch[0]);
        end
        tick();
        tests_run++;
        if (so[0] !== 4'h0 || fa[0] !== 4'hF || ri[0] !== 4'h0 || ch[0] !== 1'b1) begin
            fails++; $display("FAIL reset_edge2 sync_out=%h fall=%h rise=%h changed=%b expected 0/F/0/1", so[0], fa[0], ri[0], ch[0]);
        end
        tick();
        tests_run++;
        if (so[0] !== 4'h0 || fa[0] !== 4'h0 || ch[0] !== 1'b0) begin
            fails++; $display("FAIL reset_edge3 sync_out=%h fall=%h changed=%b expected 0/0/0", so[0], fa[0], ch[0]);
        end
    endtask

    task automatic test_latency();
        int nfall = 0;
        int nchg  = 0;
        in_v[1] = 4'hF;
        ticks(12);
        in_v[1][0] = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            tests_run++;
            if (so[1][0] !== (e >= 7 ? 1'b0 : 1'b1)) begin
                fails++; $display("FAIL latency_edge%0d sync_out[0]=%b expected=%b", e, so[1][0], (e >= 7 ? 1'b0 : 1'b1));
            end
            if (fa[1][0]) nfall++;
            if (ch[1])    nchg++;
            if (e == 7) begin
                tests_run++;
                if (fa[1][0] !== 1'b1) begin
                    fails++; $display("FAIL latency_fall_at7 fall[0]=%b expected=1", fa[1][0]);
                end
            end
        end
        tests_run++;
        if (nfall != 1 || nchg != 1) begin
            fails++; $display("FAIL latency_pulse_count fall=%0d changed=%0d expected 1/1", nfall, nchg);
        end
    endtask

    task automatic test_glitch();
        int npulse   = 0;
        int nstay    = 0;
        int fall_at  = -1;
        int rise_at  = -1;
        int nfall    = 0;
        int nrise    = 0;
        // 3-cycle low excursion: shorter than F, must vanish.
        in_v[1][1] = 1'b0;
        for (int e = 1; e <= 18; e++) begin
            if (e == 4) in_v[1][1] = 1'b1;
            tick();
            if (so[1][1] !== 1'b1) nstay++;
            if (ri[1][1] || fa[1][1]) npulse++;
        end
        tests_run++;
        if (nstay != 0 || npulse != 0) begin
            fails++; $display("FAIL glitch_short low_cycles=%0d pulses=%0d expected 0/0", nstay, npulse);
        end
        // 4-cycle low excursion: exactly F, must pass and then return.
        in_v[1][1] = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            if (e == 5) in_v[1][1] = 1'b1;
            tick();
            if (fa[1][1]) begin nfall++; fall_at = e; end
            if (ri[1][1]) begin nrise++; rise_at = e; end
        end
        tests_run++;
        if (nfall != 1 || nrise != 1) begin
            fails++; $display("FAIL glitch_long_counts fall=%0d rise=%0d expected 1/1", nfall, nrise);
        end
        tests_run++;
        if (fall_at != 7 || rise_at != 11) begin
            fails++; $display("FAIL glitch_long_timing fall_at=%0d rise_at=%0d expected 7/11", fall_at, rise_at);
        end
        tests_run++;
        if (so[1][1] !== 1'b1) begin
            fails++; $display("FAIL glitch_long_final sync_out[1]=%b expected=1", so[1][1]);
        end
    endtask

    task automatic test_simultaneous();
        in_v[0] = 4'hF;
        in_v[1] = 4'hF;
        ticks(12);
        in_v[0] = 4'h5;
        in_v[1] = 4'h5;
        for (int e = 1; e <= 9; e++) begin
            tick();
            if (e == 2) begin
                tests_run++;
                if (so[0] !== 4'h5 || fa[0] !== 4'hA || ri[0] !== 4'h0 || ch[0] !== 1'b1) begin
                    fails++; $display("FAIL simul_f0 sync_out=%h fall=%h rise=%h changed=%b expected 5/A/0/1", so[0], fa[0], ri[0], ch[0]);
                end
            end
            if (e == 3) begin
                tests_run++;
                if (fa[0] !== 4'h0 || ch[0] !== 1'b0) begin
                    fails++; $display("FAIL simul_f0_once fall=%h changed=%b expected 0/0", fa[0], ch[0]);
                end
            end
            if (e == 6) begin
                tests_run++;
                if (so[1] !== 4'hF || ch[1] !== 1'b0) begin
                    fails++; $display("FAIL simul_f4_early sync_out=%h changed=%b expected F/0", so[1], ch[1]);
                end
            end
            if (e == 7) begin
                tests_run++;
                if (so[1] !== 4'h5 || fa[1] !== 4'hA || ri[1] !== 4'h0 || ch[1] !== 1'b1) begin
                    fails++; $display("FAIL simul_f4 sync_out=%h fall=%h rise=%h changed=%b expected 5/A/0/1", so[1], fa[1], ri[1], ch[1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_filter();
        in_v[2] = 4'hF;
        ticks(12);
        in_v[2][0] = 1'b0;
        ticks(7);                       // count has reached 5
        tests_run++;
        if (so[2][0] !== 1'b1) begin
            fails++; $display("FAIL midfilt_before_reset sync_out[0]=%b expected=1", so[2][0]);
        end
        assert_reset();
        ticks(2);
        reset = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            tests_run++;
            if (so[2][0] !== (e >= 10 ? 1'b0 : 1'b1)) begin
                fails++; $display("FAIL midfilt_edge%0d sync_out[0]=%b expected=%b", e, so[2][0], (e >= 10 ? 1'b0 : 1'b1));
            end
            if (e == 10) begin
                tests_run++;
                if (fa[2][0] !== 1'b1) begin
                    fails++; $display("FAIL midfilt_fall fall[0]=%b expected=1", fa[2][0]);
                end
            end
        end
    endtask

    task automatic test_toggle();
        int nbad   = 0;
        int npulse = 0;
        in_v[3] = 4'hF;
        ticks(8);
        for (int e = 0; e < 100; e++) begin
            in_v[3][2] = ~in_v[3][2];
            tick();
            if (so[3][2] !== 1'b1) nbad++;
            if (ri[3][2] || fa[3][2]) npulse++;
        end
        in_v[3][2] = 1'b1;
        tests_run++;
        if (nbad != 0) begin
            fails++; $display("FAIL toggle_level cycles_changed=%0d expected=0", nbad);
        end
        tests_run++;
        if (npulse != 0) begin
            fails++; $display("FAIL toggle_pulses pulses=%0d expected=0", npulse);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] flip;
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NDUT; k++) begin
                flip = '0;
                for (int i = 0; i < W; i++)
                    flip[i] = ($urandom_range(0, (k == 2) ? 11 : 5) == 0);
                in_v[k] = in_v[k] ^ flip;
            end
            tick();
            for (int k = 0; k < NDUT; k++) begin
                tests_run++;
                if (so[k] !== exp_sync(k) || ri[k] !== exp_rise(k) || fa[k] !== exp_fall(k) ||
                    ch[k] !== |(exp_rise(k) | exp_fall(k))) begin
                    fails++;
                    $display("FAIL random_dut%0d cyc=%0d sync=%h rise=%h fall=%h chg=%b expected %h/%h/%h/%b",
                             k, n, so[k], ri[k], fa[k], ch[k], exp_sync(k), exp_rise(k), exp_fall(k),
                             |(exp_rise(k) | exp_fall(k)));
                end
            end
        end
    endtask

    // ---------------------------------------------------------- sequencer
    initial begin
        tests_run = 0;
        fails     = 0;
        for (int k = 0; k < NDUT; k++) in_v[k] = 4'hF;
        reset = 1'b1;
        model_reset();
        ticks(3);
        reset = 1'b0;
        ticks(4);

        test_reset();
        test_latency();
        test_glitch();
        test_simultaneous();
        test_reset_mid_filter();
        test_toggle();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule : tb_qch_sync_bank
